// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first, carry held in a flop.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             OVF
`endif
);
   // state   | meaning
   // S_IDLE  | waiting for START
   // S_SHIFT | adding one bit pair per cycle
   // S_DONE  | result just published; START here restarts immediately
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               s1, c1, s2, c2;
`ifdef SERIAL_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   half_adder u_ha1 (.a(a_sr_q[0]), .b(b_sr_q[0]), .s(s1), .c(c1));
   half_adder u_ha2 (.a(s1),        .b(carry_q),   .s(s2), .c(c2));

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               a_sr_d  = A;
               b_sr_d  = B;
               carry_d = CIN;
               cnt_d   = '0;
               res_d   = '0;
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
            res_d   = {s2, res_q[WIDTH-1:1]};
            carry_d = c1 | c2;
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               sum_d   = {s2, res_q[WIDTH-1:1]};
               cout_d  = c1 | c2;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = carry_q ^ (c1 | c2);
`endif
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign BUSY = (state_q == S_SHIFT);
   assign DONE = (state_q == S_DONE);
   assign SUM  = sum_q;
   assign COUT = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: cycle-level behavioural model plus directed literal checks.
// Covers the OVF output when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;
   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         START = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         CIN = 1'b0;
   logic         BUSY, DONE, COUT;
   logic [W-1:0] SUM;
`ifdef SERIAL_ADDER_OVF_EN
   logic         OVF;
`endif

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   serial_adder #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
      .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT)
`ifdef SERIAL_ADDER_OVF_EN
      , .OVF(OVF)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sval(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
   endfunction

   // Model: an accepted request keeps BUSY high for W cycles, then publishes A+B+CIN with a DONE pulse.
   int           m_rem = 0;
   bit           m_done = 0;
   logic [W:0]   m_pend = '0;
   bit           m_povf = 0;
   logic [W-1:0] m_sum = '0;
   bit           m_cout = 0;
   bit           m_ovf = 0;

   always @(posedge CLK) begin
      if (RST) begin
         m_rem = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
      end else if (m_rem == 0 && START) begin
         int s;
         m_pend = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, CIN};
         s = sval(A) + sval(B) + int'(CIN);
         m_povf = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
         m_rem = W;
         m_done = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_done = 1;
            m_sum = m_pend[W-1:0];
            m_cout = m_pend[W];
            m_ovf = m_povf;
         end
      end else begin
         m_done = 0;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("busy", BUSY, m_rem > 0);
         check("done", DONE, m_done);
         check("sum",  SUM,  m_sum);
         check("cout", COUT, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
         check("ovf",  OVF,  m_ovf);
`endif
         if (BUSY && DONE) check("busy_and_done", 1, 0);
      end
   end

   // Presents operands for one edge; returns in cycle 1 of the operation.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      @(posedge CLK); #1;
      START = 1'b1; A = a; B = b; CIN = cin;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!DONE && n < 30);
      if (!DONE) check("done_timeout", 0, 1);
   endtask

   int n;

   initial begin
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      chk_en = 1'b1;
      @(negedge CLK);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_sum",  SUM,  0);
      check("rst_cout", COUT, 0);

      start_op(8'h35, 8'h4A, 1'b0);
      wait_done(n);
      check("lat_35_4a", n, 9);
      check("sum_35_4a", SUM, 8'h7F);
      check("cout_35_4a", COUT, 0);

      start_op(8'hFF, 8'h00, 1'b1);
      wait_done(n);
      check("sum_ff_00_1", SUM, 8'h00);
      check("cout_ff_00_1", COUT, 1);
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf_ff_00_1", OVF, 0);
`endif

      start_op(8'h7F, 8'h01, 1'b0);
      wait_done(n);
      check("sum_7f_01", SUM, 8'h80);
      check("cout_7f_01", COUT, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("ovf_7f_01", OVF, 1);
`endif

      // START in cycle 4 must be ignored; START in the DONE cycle restarts back-to-back.
      start_op(8'h35, 8'h4A, 1'b0);
      repeat (3) @(posedge CLK);
      #1 START = 1'b1; A = 8'h01;
      @(posedge CLK); #1 START = 1'b0;
      wait_done(n);
      check("ign_sum", SUM, 8'h7F);
      START = 1'b1; A = 8'h10; B = 8'h20; CIN = 1'b0;
      @(posedge CLK); #1 START = 1'b0;
      wait_done(n);
      check("b2b_lat", n, 9);
      check("b2b_sum", SUM, 8'h30);

      // Reset in cycle 5 aborts with no DONE afterwards.
      start_op(8'hC3, 8'h5A, 1'b1);
      repeat (4) @(posedge CLK);
      #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
      check("abort_sum",  SUM,  0);
      check("abort_cout", COUT, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (DONE) check("abort_no_done", DONE, 0);
      end

      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb;
         logic         rc;
         logic [W:0]   ref_v;
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         start_op(ra, rb, rc);
         wait_done(n);
         check("rand_sum",  SUM,  ref_v[W-1:0]);
         check("rand_cout", COUT, ref_v[W]);
      end

      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
